// File: rtl/win_pkg.sv
// -----------------------------------------------------------------------------
// win_pkg
// Shared width helpers for the decimating sliding-window accumulator.
//   clog2   : ceiling log2 usable in constant expressions (clog2(1) = 0)
//   acc_w   : block accumulator width, DIN_W + clog2(DECIM)
//   sum_w   : window sum width, acc_w + clog2(DEPTH)
//   cnt_w   : width of the partial-block sample counter, clog2(DECIM+1)
//   fill_w  : width of the fill-state counter, clog2(DEPTH+1)
//   ptr_w   : ring pointer width, never below 1 so DEPTH=1 still has a pointer
// -----------------------------------------------------------------------------
package win_pkg;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

    function automatic int acc_w(input int din_w, input int decim);
        return din_w + clog2(decim);
    endfunction

    function automatic int sum_w(input int din_w, input int decim, input int depth);
        return acc_w(din_w, decim) + clog2(depth);
    endfunction

    function automatic int cnt_w(input int decim);
        return clog2(decim + 1);
    endfunction

    function automatic int fill_w(input int depth);
        return clog2(depth + 1);
    endfunction

    function automatic int ptr_w(input int depth);
        return (clog2(depth) < 1) ? 1 : clog2(depth);
    endfunction

endpackage

// File: rtl/win_ring_buf.sv
// -----------------------------------------------------------------------------
// win_ring_buf
// DEPTH x ACC_W register ring holding the most recent block sums.
//   clk      : clock
//   flush    : synchronous clear of contents and pointer (rst or clr)
//   wr_en    : store wr_data at the current slot and advance the pointer
//   wr_data  : block sum to store
//   rd_data  : combinational read of the current slot, i.e. the oldest block
//              once the ring is full (the slot about to be overwritten)
// -----------------------------------------------------------------------------
module win_ring_buf
    import win_pkg::*;
#(
    parameter int DEPTH = 5,
    parameter int ACC_W = 33
) (
    input  logic                    clk,
    input  logic                    flush,
    input  logic                    wr_en,
    input  logic signed [ACC_W-1:0] wr_data,
    output logic signed [ACC_W-1:0] rd_data
);

    localparam int PTR_W = ptr_w(DEPTH);

    logic signed [ACC_W-1:0] mem [DEPTH];
    logic        [PTR_W-1:0] wr_ptr;

    assign rd_data = mem[wr_ptr];

    // NOTE: the ring is a handful of registers, so clearing it on flush is
    // cheap and guarantees no stale block survives into a refilled window.
    always_ff @(posedge clk) begin
        if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
        end else if (wr_en) begin
            mem[wr_ptr] <= wr_data;
            if (wr_ptr == PTR_W'(DEPTH - 1)) begin
                wr_ptr <= '0;
            end else begin
                wr_ptr <= wr_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/window_accum.sv
// -----------------------------------------------------------------------------
// window_accum
// Decimating sliding-window accumulator: sums DECIM valid samples into a block,
// keeps a running sum of the last DEPTH blocks (add newest, subtract oldest)
// and emits one scaled window sum per completed block once the window is full.
//   clk       : clock
//   rst       : synchronous active-high reset, highest priority
//   clr       : synchronous flush, same effect as rst
//   in_valid  : din accepted on this edge
//   din       : signed sample, DIN_W bits
//   out_valid : one-cycle pulse, dout carries a new window sum
//   dout      : signed scaled window sum, SUM_W bits, held between pulses
//   win_full  : DEPTH blocks stored since reset/clr
//   blk_cnt   : valid samples in the current partial block
// Build option: define WINDOW_ACCUM_ROUND_EN for round-half-up scaling;
// otherwise the output shift truncates toward minus infinity.
// -----------------------------------------------------------------------------
module window_accum
    import win_pkg::*;
#(
    parameter int DIN_W = 25,
    parameter int DECIM = 250,
    parameter int DEPTH = 5,
    parameter int SHIFT = 0
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      clr,
    input  logic                                      in_valid,
    input  logic signed [DIN_W-1:0]                   din,
    output logic                                      out_valid,
    output logic signed [sum_w(DIN_W,DECIM,DEPTH)-1:0] dout,
    output logic                                      win_full,
    output logic        [cnt_w(DECIM)-1:0]            blk_cnt
);

    localparam int ACC_W  = acc_w(DIN_W, DECIM);
    localparam int SUM_W  = sum_w(DIN_W, DECIM, DEPTH);
    localparam int CNT_W  = cnt_w(DECIM);
    localparam int FILL_W = fill_w(DEPTH);

    logic                    flush;
    logic signed [ACC_W-1:0] din_ext;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] blk_q;
    logic                    blk_v;
    logic                    blk_last;
    logic signed [ACC_W-1:0] ring_rd;
    logic signed [ACC_W-1:0] old_blk;
    logic signed [SUM_W-1:0] sum;
    logic signed [SUM_W-1:0] sum_next;
    logic signed [SUM_W-1:0] dout_next;
    logic        [FILL_W-1:0] fill;
    logic                    win_full_next;

    assign flush    = rst | clr;
    assign din_ext  = ACC_W'(din);
    assign blk_last = in_valid && (blk_cnt == CNT_W'(DECIM - 1));

    win_ring_buf #(
        .DEPTH (DEPTH),
        .ACC_W (ACC_W)
    ) u_ring (
        .clk     (clk),
        .flush   (flush),
        .wr_en   (blk_v),
        .wr_data (blk_q),
        .rd_data (ring_rd)
    );

    // Until the window is full the ring slot ahead holds no real block, so
    // nothing is retired from the running sum.
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        old_blk       = '0;
        sum_next      = sum;
        win_full_next = win_full;
        if (win_full) begin
            old_blk = ring_rd;
        end
        sum_next      = sum + SUM_W'(blk_q) - SUM_W'(old_blk);
        win_full_next = (int'(fill) + 1 >= DEPTH);
    end

`ifdef WINDOW_ACCUM_ROUND_EN
    if (SHIFT == 0) begin : g_scale_pass
        assign dout_next = sum_next;
    end else begin : g_scale_round
        // One extra bit so adding the half-LSB can never wrap.
        logic signed [SUM_W:0] sum_ext;
        logic signed [SUM_W:0] rounded;
        assign sum_ext   = (SUM_W + 1)'(sum_next);
        assign rounded   = (sum_ext + (SUM_W + 1)'(2 ** (SHIFT - 1))) >>> SHIFT;
        assign dout_next = rounded[SUM_W-1:0];
    end
`else
    assign dout_next = sum_next >>> SHIFT;
`endif

    // NOTE: all state here is updated with non-blocking assignments so every
    // register samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (flush) begin
            acc       <= '0;
            blk_cnt   <= '0;
            blk_q     <= '0;
            blk_v     <= 1'b0;
            sum       <= '0;
            fill      <= '0;
            win_full  <= 1'b0;
            out_valid <= 1'b0;
            dout      <= '0;
        end else begin
            out_valid <= 1'b0;
            blk_v     <= blk_last;

            if (in_valid) begin
                if (blk_last) begin
                    blk_q   <= acc + din_ext;
                    acc     <= '0;
                    blk_cnt <= '0;
                end else begin
                    acc     <= acc + din_ext;
                    blk_cnt <= blk_cnt + 1'b1;
                end
            end

            if (blk_v) begin
                sum      <= sum_next;
                win_full <= win_full_next;
                if (int'(fill) < DEPTH) begin
                    fill <= fill + 1'b1;
                end
                if (win_full_next) begin
                    out_valid <= 1'b1;
                    dout      <= dout_next;
                end
            end
        end
    end

endmodule

// File: tb/tb_window_accum.sv
// -----------------------------------------------------------------------------
// tb_window_accum
// Two instances (SHIFT=0 and SHIFT=2) share one stimulus stream. A queue-based
// model of blocks and windows predicts out_valid/dout/win_full/blk_cnt on every
// cycle; directed literals pin the expected window sums per scenario.
// -----------------------------------------------------------------------------
module tb_window_accum;

    localparam int DIN_W = 8;
    localparam int DECIM = 4;
    localparam int DEPTH = 3;
    localparam int SUM_W = 12;
    localparam int CNT_W = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clr = 1'b0;
    logic in_valid = 1'b0;
    logic signed [DIN_W-1:0] din = '0;

    logic                    out_valid0, win_full0, out_valid2, win_full2;
    logic signed [SUM_W-1:0] dout0, dout2;
    logic        [CNT_W-1:0] blk_cnt0, blk_cnt2;

    int n_checks = 0;
    int n_fail   = 0;
    bit started  = 1'b0;

    always #5 clk = ~clk;

    window_accum #(.DIN_W(DIN_W), .DECIM(DECIM), .DEPTH(DEPTH), .SHIFT(0)) dut0 (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .din(din),
        .out_valid(out_valid0), .dout(dout0), .win_full(win_full0), .blk_cnt(blk_cnt0)
    );

    window_accum #(.DIN_W(DIN_W), .DECIM(DECIM), .DEPTH(DEPTH), .SHIFT(2)) dut2 (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .din(din),
        .out_valid(out_valid2), .dout(dout2), .win_full(win_full2), .blk_cnt(blk_cnt2)
    );

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int scaled2(input int s);
`ifdef WINDOW_ACCUM_ROUND_EN
        return (s + 2) >>> 2;
`else
        return s >>> 2;
`endif
    endfunction

    // ---------------- behavioural model ----------------
    int part_sum = 0;
    int part_cnt = 0;
    int blocks[$];
    bit pend_v = 1'b0;
    int pend_sum = 0;
    bit exp_v = 1'b0;
    int exp_sum = 0;
    bit exp_full = 1'b0;
    int model_outs[$];

    always @(posedge clk) begin
        if (rst || clr) begin
            part_sum = 0; part_cnt = 0; blocks.delete();
            pend_v = 1'b0; exp_v = 1'b0; exp_sum = 0; exp_full = 1'b0;
        end else begin
            exp_v = pend_v;
            if (pend_v) begin
                exp_sum  = pend_sum;
                exp_full = 1'b1;
                model_outs.push_back(pend_sum);
            end
            pend_v = 1'b0;
            if (in_valid) begin
                part_sum += int'(din);
                part_cnt++;
                if (part_cnt == DECIM) begin
                    blocks.push_back(part_sum);
                    part_sum = 0;
                    part_cnt = 0;
                    if (blocks.size() >= DEPTH) begin
                        pend_v   = 1'b1;
                        pend_sum = 0;
                        for (int i = blocks.size() - DEPTH; i < blocks.size(); i++)
                            pend_sum += blocks[i];
                    end
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    int dut_outs[$];
    int dut2_outs[$];

    always @(negedge clk) begin
        if (started) begin
            check("out_valid0", int'(out_valid0), int'(exp_v));
            check("out_valid2", int'(out_valid2), int'(exp_v));
            check("dout0", int'(dout0), exp_sum);
            check("dout2", int'(dout2), scaled2(exp_sum));
            check("win_full0", int'(win_full0), int'(exp_full));
            check("blk_cnt0", int'(blk_cnt0), part_cnt);
            check("blk_cnt2", int'(blk_cnt2), part_cnt);
            if (out_valid0) dut_outs.push_back(int'(dout0));
            if (out_valid2) dut2_outs.push_back(int'(dout2));
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input bit v, input int d);
        in_valid = v;
        din      = DIN_W'(d);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 0);
    endtask

    task automatic flush_clr();
        clr = 1'b1;
        step(1'b0, 0);
        clr = 1'b0;
        dut_outs.delete(); dut2_outs.delete(); model_outs.delete();
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_ov"},   int'(out_valid0), 0);
        check({tag, "_dout"}, int'(dout0), 0);
        check({tag, "_full"}, int'(win_full0), 0);
        check({tag, "_cnt"},  int'(blk_cnt0), 0);
    endtask

    initial begin
        int accepted;
        rst = 1'b1;
        step(1'b0, 0);
        step(1'b0, 0);
        rst = 1'b0;
        started = 1'b1;
        check_zero("reset");

        // Constant 1: first output two edges after the 12th sample.
        for (int i = 0; i < 12; i++) step(1'b1, 1);
        check("lat_pending_ov", int'(out_valid0), 0);
        step(1'b0, 0);
        check("lat_first_ov", int'(out_valid0), 1);
        check("lat_first_dout", int'(dout0), 12);
        check("lat_full", int'(win_full0), 1);
        for (int i = 0; i < 8; i++) step(1'b1, 1);
        idle(3);
        check("const_n_out", dut_outs.size(), 3);
        check("const_last", dut_outs[dut_outs.size()-1], 12);
        check("const_model", model_outs[2], 12);
        flush_clr();

        // Ramp: block sums 6, 22, 38, 54.
        for (int i = 0; i < 16; i++) step(1'b1, i);
        idle(3);
        check("ramp_n_out", dut_outs.size(), 2);
        check("ramp_out0", dut_outs[0], 66);
        check("ramp_out1", dut_outs[1], 114);
        check("ramp_model1", model_outs[1], 114);
        flush_clr();

        // Most negative input over a full window.
        for (int i = 0; i < 12; i++) step(1'b1, -128);
        idle(3);
        check("neg_out", dut_outs[0], -1536);
        check("neg_out_s2", dut2_outs[0], -384);
        flush_clr();

        // Window sums 6 then -6 through the SHIFT=2 instance.
        for (int b = 0; b < 3; b++) begin
            step(1'b1, 1); step(1'b1, 1); step(1'b1, 0); step(1'b1, 0);
        end
        step(1'b1, -3); step(1'b1, -3); step(1'b1, -2); step(1'b1, -2);
        idle(3);
        check("shift_sum_pos", dut_outs[0], 6);
        check("shift_sum_neg", dut_outs[1], -6);
`ifdef WINDOW_ACCUM_ROUND_EN
        check("shift_pos_s2", dut2_outs[0], 2);
        check("shift_neg_s2", dut2_outs[1], -1);
`else
        check("shift_pos_s2", dut2_outs[0], 1);
        check("shift_neg_s2", dut2_outs[1], -2);
`endif
        flush_clr();

        // Random in_valid gaps over 24 accepted samples.
        accepted = 0;
        for (int i = 0; i < 300 && accepted < 24; i++) begin
            bit v;
            v = bit'($urandom_range(0, 1));
            step(v, int'($urandom_range(0, 255)) - 128);
            if (v) accepted++;
        end
        check("rand_accepted", accepted, 24);
        idle(3);
        check("rand_n_out", dut_outs.size(), 4);
        check("rand_model_n", model_outs.size(), 4);
        flush_clr();

        // rst after the 7th sample, then refill.
        for (int i = 0; i < 7; i++) step(1'b1, 1);
        rst = 1'b1;
        step(1'b0, 0);
        rst = 1'b0;
        check_zero("rst_mid");
        dut_outs.delete();
        for (int i = 0; i < 11; i++) step(1'b1, 1);
        idle(3);
        check("rst_refill_none", dut_outs.size(), 0);
        step(1'b1, 1);
        idle(3);
        check("rst_refill_one", dut_outs.size(), 1);
        check("rst_refill_val", dut_outs[0], 12);

        // clr coincident with the 4th sample of a block.
        for (int i = 0; i < 3; i++) step(1'b1, 5);
        clr = 1'b1;
        step(1'b1, 5);
        clr = 1'b0;
        check_zero("clr_blk");
        dut_outs.delete();
        for (int i = 0; i < 11; i++) step(1'b1, 1);
        idle(3);
        check("clr_refill_none", dut_outs.size(), 0);
        step(1'b1, 1);
        idle(3);
        check("clr_refill_one", dut_outs.size(), 1);
        check("clr_refill_val", dut_outs[0], 12);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
